// File: rtl/modmul_pipe_2579.sv
// modmul_pipe_2579: three-stage Barrett pipeline computing (a*b) mod Q with valid/ready on both sides
module modmul_pipe_2579 #(
    parameter int Q     = 2579,
    parameter int MU    = 6505,
    parameter int K     = 12,
    parameter int W     = 12,
    parameter int PW    = 23,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [W-1:0]     in_a_i,
    input  logic [W-1:0]     in_b_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [W-1:0]     out_r_o,
    output logic [TAG_W-1:0] out_tag_o,
    output logic             out_oor_o
);

    logic             en;
    logic             v1_q, v2_q;
    logic             oor1_q, oor2_q;
    logic [TAG_W-1:0] tag1_q, tag2_q;
    logic [PW-1:0]    p1_q, p2_q, m2_q;
    logic [PW-1:0]    p1_d, m2_d;
    logic             oor1_d;
    logic [W-1:0]     t;
    logic [13:0]      r0;
    logic [W-1:0]     out_r_d;

    // The whole pipe moves together; it only freezes when a finished result is not taken.
    assign en         = !out_valid_o || out_ready_i;
    assign in_ready_o = en && !rst;

    // Stage arithmetic: product, Barrett quotient estimate, then final remainder correction.
    always_comb begin
        p1_d    = PW'({{W{1'b0}}, in_a_i} * {{W{1'b0}}, in_b_i});
        oor1_d  = (in_a_i >= W'(Q)) || (in_b_i >= W'(Q));
        t       = W'((24'(p1_q[PW-1:K]) * 24'(MU)) >> K);
        m2_d    = PW'(t) * PW'(Q);
        r0      = 14'(p2_q - m2_q);
        out_r_d = W'(r0 >= 14'(3 * Q) ? r0 - 14'(3 * Q) :
                      r0 >= 14'(2 * Q) ? r0 - 14'(2 * Q) :
                      r0 >= 14'(Q)     ? r0 - 14'(Q)     : r0);
    end

    // Pipeline registers; bubbles travel as valid=0 and reset drops everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            oor1_q      <= 1'b0;
            oor2_q      <= 1'b0;
            tag1_q      <= '0;
            tag2_q      <= '0;
            p1_q        <= '0;
            p2_q        <= '0;
            m2_q        <= '0;
            out_valid_o <= 1'b0;
            out_r_o     <= '0;
            out_tag_o   <= '0;
            out_oor_o   <= 1'b0;
        end else if (en) begin
            v1_q        <= in_valid_i;
            oor1_q      <= oor1_d;
            tag1_q      <= in_tag_i;
            p1_q        <= p1_d;
            v2_q        <= v1_q;
            oor2_q      <= oor1_q;
            tag2_q      <= tag1_q;
            p2_q        <= p1_q;
            m2_q        <= m2_d;
            out_valid_o <= v2_q;
            out_r_o     <= out_r_d;
            out_tag_o   <= tag2_q;
            out_oor_o   <= oor2_q;
        end
    end

endmodule

// File: tb/tb_modmul_pipe_2579.sv
// tb_modmul_pipe_2579: table vectors, boundary sweep, stalls, throughput and random traffic against a % model
module tb_modmul_pipe_2579;

    localparam int Q = 2579;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid, in_ready, out_valid, out_ready, out_oor;
    logic [11:0] in_a, in_b, out_r;
    logic [3:0]  in_tag, out_tag;

    always #5 clk = ~clk;

    modmul_pipe_2579 dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_a_i(in_a), .in_b_i(in_b), .in_tag_i(in_tag),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_r_o(out_r), .out_tag_o(out_tag), .out_oor_o(out_oor)
    );

    typedef struct { int r; int tag; bit oor; } exp_t;
    typedef struct { int a; int b; int tag; int r; bit oor; } vec_t;

    exp_t        q[$];
    exp_t        nxt;
    vec_t        vt[6];
    int          bv[7] = '{0, 1, 2, 1289, 1290, 2577, 2578};
    int          n_cmp = 0, n_err = 0, cyc = 0, n_pop = 0, last_pop_cyc = 0;
    bit          acc = 0, stall_prev = 0;
    logic [11:0] h_r;
    logic [3:0]  h_tag;
    logic        h_oor;

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int rnd_op();
        return ($urandom_range(0, 15) == 0) ? int'($urandom_range(Q, 4095)) : int'($urandom_range(0, Q - 1));
    endfunction

    // Present an operand pair; the expected result comes from plain modular arithmetic.
    task automatic drive(int a, int b, int tag);
        in_valid = 1'b1;
        in_a     = a[11:0];
        in_b     = b[11:0];
        in_tag   = tag[3:0];
        nxt.r    = (a * b) % Q;
        nxt.tag  = tag & 15;
        nxt.oor  = (a >= Q) || (b >= Q);
    endtask

    // One clock: observe outputs, score transfers, record acceptance, advance to the next falling edge.
    task automatic tick();
        exp_t e;
        #1;
        chk("in_ready", in_ready, int'((!out_valid || out_ready) && !rst));
        if (stall_prev) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_r", out_r, h_r);
            chk("hold_tag", out_tag, h_tag);
            chk("hold_oor", out_oor, h_oor);
        end
        stall_prev = out_valid && !out_ready && !rst;
        h_r   = out_r;
        h_tag = out_tag;
        h_oor = out_oor;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_out: got r=%0d tag=%0d with nothing outstanding", out_r, out_tag);
            end else begin
                e = q.pop_front();
                if (!e.oor) chk("out_r", out_r, e.r);
                chk("out_tag", out_tag, e.tag);
                chk("out_oor", out_oor, int'(e.oor));
                n_pop++;
                last_pop_cyc = cyc;
            end
        end
        acc = in_valid && in_ready;
        if (acc) q.push_back(nxt);
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (q.size() > 0 && n < 100) begin
            tick();
            n++;
        end
        if (q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: got %0d results missing, required 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        int n, sent, c, c0, base;
        vt[0] = '{2578, 2578, 1, 1, 0};
        vt[1] = '{0, 1234, 2, 0, 0};
        vt[2] = '{1, 2578, 3, 2578, 0};
        vt[3] = '{1290, 2, 4, 1, 0};
        vt[4] = '{2579, 5, 7, 0, 1};
        vt[5] = '{3, 4, 8, 12, 0};
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_r", out_r, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_out_oor", out_oor, 0);
        chk("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        // single transaction latency on an idle pipe
        drive(5, 7, 9);
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        chk("latency", n, 2);
        drain();
        // directed table, including the out-of-range pair and its follower
        foreach (vt[i]) begin
            drive(vt[i].a, vt[i].b, vt[i].tag);
            nxt.r   = vt[i].r;
            nxt.oor = vt[i].oor;
            tick();
        end
        drain();
        // operand boundary sweep
        foreach (bv[i]) foreach (bv[j]) begin
            drive(bv[i], bv[j], i * 7 + j);
            tick();
        end
        drain();
        // backpressure: out_ready 1,0,0,1,0,0 while 20 pairs stream in
        sent = 0;
        c    = 0;
        drive(rnd_op(), rnd_op(), 0);
        while (sent < 20 && c < 300) begin
            out_ready = (c % 3 == 0);
            tick();
            c++;
            if (acc) begin
                sent++;
                if (sent < 20) drive(rnd_op(), rnd_op(), sent);
            end
        end
        chk("bp_sent", sent, 20);
        drain();
        // full throughput: 100 pairs, tags wrap through 0..15
        c0   = cyc;
        base = n_pop;
        for (int i = 0; i < 100; i++) begin
            drive($urandom_range(0, Q - 1), $urandom_range(0, Q - 1), i);
            tick();
            chk("tp_accept", acc, 1);
        end
        in_valid = 1'b0;
        n = 0;
        while (n_pop - base < 100 && n < 20) begin
            tick();
            n++;
        end
        chk("tp_results", n_pop - base, 100);
        chk("tp_cycles", last_pop_cyc - c0, 102);
        drain();
        // random valid/ready traffic
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid || acc) begin
                if ($urandom_range(0, 3) != 0) drive(rnd_op(), rnd_op(), $urandom_range(0, 15));
                else in_valid = 1'b0;
            end
            tick();
        end
        drain();
        // reset with three transactions in flight
        for (int i = 0; i < 3; i++) begin
            drive(100 + i, 200 + i, 10 + i);
            tick();
        end
        in_valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_r", out_r, 0);
        chk("midrst_in_ready", in_ready, 0);
        q.delete();
        stall_prev = 1'b0;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        drive(1111, 2222, 5);
        tick();
        chk("post_rst_accept", acc, 1);
        drain();
        chk("post_rst_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
